// File: rtl/mdu_sequencer_pkg.sv
// Shared definitions for the multiply/divide unit.
//   mdu_op_e    : MDU_OP field encodings driven from the E-stage decode
//   mdu_state_e : sequencer FSM states
//   *_DEF       : default latencies / counter width
package mdu_sequencer_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath.
//   op, madd       : operation select (madd only meaningful for mult/multu)
//   src_a, src_b   : rs / rt operands
//   hi, lo         : current committed HI/LO (accumulator for madd)
//   res            : {hi, lo} result; div: {remainder, quotient}
//   div_by_zero    : divide op with src_b == 0 (result must not commit)
module mdu_arith
  import mdu_sequencer_pkg::*;
(
  input  mdu_op_e     op,
  input  logic        madd,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        div_by_zero
);

  logic [63:0] prod_s, prod_u, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  always_comb begin
    prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    prod_u = {32'd0, src_a} * {32'd0, src_b};
    prod   = (op == MDU_MULT) ? prod_s : prod_u;

    // Signed divide via magnitudes: avoids the -2^31 / -1 overflow corner of a
    // native signed divider. Negating 0x80000000 yields 0x80000000, which is
    // exactly the required quotient for that case.
    a_neg  = (op == MDU_DIV) & src_a[31];
    b_neg  = (op == MDU_DIV) & src_b[31];
    a_mag  = a_neg ? -src_a : src_a;
    b_mag  = b_neg ? -src_b : src_b;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;   // remainder takes the dividend's sign

    div_by_zero = op[1] & (src_b == 32'd0);

    if (op[1])     res = {rem, quot};           // madd ignored for divides
    else if (madd) res = {hi, lo} + prod;
    else           res = prod;
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer with HI/LO registers.
//   clk, reset     : clock, async active-low reset
//   START          : E-stage mult/div/madd valid
//   MDU_OP, madd   : operation select
//   WRITE_ENABLED  : mthi/mtlo strobe, HiLo selects target (and RD_DATA)
//   CANCEL         : E-stage flush; blocks new starts/writes only
//   SRC_A, SRC_B   : forwarded operands
//   BUSY           : high for exactly N cycles after an accepted start
//   HI, LO         : committed registers; RD_DATA = HiLo ? HI : LO
// The result is computed in the start cycle and parked in PEND until the
// countdown expires, so the latency is purely a scheduling property.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES  = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES   = DIV_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter bit HAZARD_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        START,
  input  logic [1:0]  MDU_OP,
  input  logic        madd,
  input  logic        WRITE_ENABLED,
  input  logic        HiLo,
  input  logic        CANCEL,
  input  logic [31:0] SRC_A,
  input  logic [31:0] SRC_B,
  output logic        BUSY,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] RD_DATA
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_wen_q, pend_wen_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [63:0]      res;
  logic             div_by_zero;
  logic             go, wr;

  mdu_arith u_arith (
    .op          (mdu_op_e'(MDU_OP)),
    .madd        (madd),
    .src_a       (SRC_A),
    .src_b       (SRC_B),
    .hi          (hi_q),
    .lo          (lo_q),
    .res         (res),
    .div_by_zero (div_by_zero)
  );

  assign BUSY    = (state_q == MDU_RUN);
  assign HI      = hi_q;
  assign LO      = lo_q;
  assign RD_DATA = HiLo ? hi_q : lo_q;

  assign go = START & ~CANCEL & ~BUSY;
  assign wr = WRITE_ENABLED & ~CANCEL & ~BUSY & ~START;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= MDU_IDLE;
      cnt_q      <= '0;
      pend_hi_q  <= '0;
      pend_lo_q  <= '0;
      pend_wen_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      pend_wen_q <= pend_wen_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    pend_wen_d = pend_wen_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      MDU_IDLE: begin
        if (go) begin
          state_d    = MDU_RUN;
          cnt_d      = MDU_OP[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          pend_hi_d  = res[63:32];
          pend_lo_d  = res[31:0];
          pend_wen_d = ~div_by_zero;
        end else if (wr) begin
          if (HiLo) hi_d = SRC_A;
          else      lo_d = SRC_A;
        end
      end
      MDU_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = MDU_IDLE;
          if (pend_wen_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  // A new MDU request while BUSY means the hazard unit failed to stall D.
  if (HAZARD_CHECK) begin : g_hazard_chk
    always_ff @(posedge clk) begin
      if (reset)
        assert (!(BUSY && (START || WRITE_ENABLED)))
          else $error("mdu_sequencer: request while BUSY was dropped");
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        START = 1'b0, madd = 1'b0, WRITE_ENABLED = 1'b0, HiLo = 1'b0, CANCEL = 1'b0;
  logic [1:0]  MDU_OP = 2'b00;
  logic [31:0] SRC_A = '0, SRC_B = '0;
  logic        BUSY;
  logic [31:0] HI, LO, RD_DATA;

  mdu_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4), .HAZARD_CHECK(1'b0)) dut (
    .clk(clk), .reset(reset), .START(START), .MDU_OP(MDU_OP), .madd(madd),
    .WRITE_ENABLED(WRITE_ENABLED), .HiLo(HiLo), .CANCEL(CANCEL),
    .SRC_A(SRC_A), .SRC_B(SRC_B), .BUSY(BUSY), .HI(HI), .LO(LO), .RD_DATA(RD_DATA)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_op;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          wr_due = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;   // reference HI/LO after all issued work

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic straight from the op definitions.
  function automatic logic [63:0] ref_result(logic [1:0] op, bit md, logic [31:0] a,
                                             logic [31:0] b, logic [31:0] hi, logic [31:0] lo);
    longint sa, sb, ua, ub, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (op[1]) begin
      if (b == 32'd0) return {hi, lo};
      if (op == 2'b10) begin q = sa / sb; r = sa % sb; end
      else             begin q = ua / ub; r = ua % ub; end
      return {r[31:0], q[31:0]};
    end
    p = (op == 2'b00) ? sa * sb : ua * ub;
    if (md) p = p + longint'({hi, lo});
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    START = 1'b0; WRITE_ENABLED = 1'b0; CANCEL = 1'b0; madd = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 40) begin tick(); n++; end
    checks++;
    if (BUSY) begin
      failures++;
      $display("FAIL busy_timeout actual=BUSY expected=idle within 40 cycles");
    end
  endtask

  // Accepted start (DUT idle, no cancel); optionally also raise WRITE_ENABLED.
  task automatic issue(logic [1:0] op, bit md, logic [31:0] a, logic [31:0] b, bit we);
    logic [63:0] r;
    START = 1'b1; MDU_OP = op; madd = md; SRC_A = a; SRC_B = b;
    WRITE_ENABLED = we; HiLo = 1'($urandom);
    r = ref_result(op, md, a, b, m_hi, m_lo);
    exp_q.push_back('{is_op: 1'b1, hi: r[63:32], lo: r[31:0], len: op[1] ? DIV_N : MULT_N});
    m_hi = r[63:32];
    m_lo = r[31:0];
    tick();
    idle_inputs();
  endtask

  task automatic mt(bit sel, logic [31:0] a);
    WRITE_ENABLED = 1'b1; HiLo = sel; SRC_A = a; SRC_B = $urandom;
    if (sel) m_hi = a; else m_lo = a;
    tick();
    idle_inputs();
    exp_q.push_back('{is_op: 1'b0, hi: m_hi, lo: m_lo, len: 0});
    wr_due = 1'b1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops one expectation per completed operation (BUSY falling) or write.
  initial begin : monitor
    int   run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (!reset) run = 0;
      else if (BUSY) run++;
      else begin
        if (run > 0 || wr_due) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_completion actual=busy_run %0d expected=no event", run);
          end else begin
            e = exp_q.pop_front();
            chk(e.is_op ? "op_kind" : "wr_kind", 64'(run > 0), 64'(e.is_op));
            if (e.is_op) chk("busy_len", 64'(run), 64'(e.len));
            chk("hi_commit", 64'(HI), 64'(e.hi));
            chk("lo_commit", 64'(LO), 64'(e.lo));
          end
        end
        run = 0;
        wr_due = 1'b0;
      end
    end
  end

  initial begin : driver
    int n;
    repeat (2) tick();
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_hilo", {HI, LO}, 64'd0);
    chk("rst_rd", 64'(RD_DATA), 64'd0);
    reset = 1'b1;
    tick();

    // Directed cases
    issue(2'b00, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0); wait_idle();
    chk("mult_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);
    issue(2'b01, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0); wait_idle();
    chk("multu_const", {HI, LO}, 64'h0000_0001_FFFF_FFFE);
    issue(2'b10, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0); wait_idle();
    chk("div_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(2'b11, 1'b0, 32'd7, 32'd0, 1'b0); wait_idle();
    chk("divu_by0_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    mt(1'b0, 32'hFFFF_FFFF);
    chk("mtlo_busy", 64'(BUSY), 64'd0);
    mt(1'b1, 32'd0);
    tick();
    issue(2'b01, 1'b1, 32'd1, 32'd1, 1'b0); wait_idle();
    chk("maddu_const", {HI, LO}, 64'h0000_0001_0000_0000);

    // Cancelled start
    START = 1'b1; CANCEL = 1'b1; MDU_OP = 2'b00; SRC_A = 32'd3; SRC_B = 32'd3;
    tick(); idle_inputs();
    chk("cancel_busy", 64'(BUSY), 64'd0);
    chk("cancel_hilo", {HI, LO}, {m_hi, m_lo});

    // Start/write while busy are dropped; original result lands on schedule
    issue(2'b00, 1'b0, 32'd1234, 32'hFFFF_FFF0, 1'b0);
    tick();
    START = 1'b1; MDU_OP = 2'b11; SRC_A = 32'd99; SRC_B = 32'd5; CANCEL = 1'b0;
    tick(); idle_inputs();
    WRITE_ENABLED = 1'b1; HiLo = 1'b1; SRC_A = 32'hDEAD_BEEF;
    tick(); idle_inputs();
    wait_idle();

    // START + WRITE_ENABLED together: arithmetic only
    tick();
    issue(2'b01, 1'b0, 32'd6, 32'd7, 1'b1); wait_idle();
    chk("start_wins", {HI, LO}, 64'd42);

    // Signed overflow divide, then RD_DATA select toggling
    issue(2'b10, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); wait_idle();
    chk("div_ovf_const", {HI, LO}, 64'h0000_0000_8000_0000);
    for (int i = 0; i < 4; i++) begin
      HiLo = 1'(i);
      #1;
      chk("rd_data", 64'(RD_DATA), 64'(HiLo ? m_hi : m_lo));
      tick();
    end

    // Randomised mix
    for (int i = 0; i < 40; i++) begin
      tick();
      case ($urandom_range(0, 4))
        0, 1, 2: begin issue(2'($urandom), 1'($urandom), pick(), pick(), 1'b0); wait_idle(); end
        3: mt(1'($urandom), pick());
        default: begin
          START = 1'b1; CANCEL = 1'b1; MDU_OP = 2'($urandom); SRC_A = pick(); SRC_B = pick();
          tick(); idle_inputs();
          chk("rand_cancel", {31'd0, BUSY, HI}, {32'd0, m_hi});
        end
      endcase
    end
    tick();

    // Reset mid-mult aborts with no commit
    mt(1'b1, 32'h1357_9BDF);
    tick();
    issue(2'b00, 1'b0, 32'd100, 32'd100, 1'b0);
    void'(exp_q.pop_back());   // aborted by reset: never completes
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(BUSY), 64'd0);
    chk("rst_mid_hilo", {HI, LO}, 64'd0);
    m_hi = '0; m_lo = '0;
    tick(); tick();
    reset = 1'b1;
    repeat (8) tick();
    chk("rst_no_commit", {31'd0, BUSY, HI, LO}, 96'd0);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
Multi-cycle multiply/divide unit with a HI/LO register pair. It is driven from the E stage by the decoded MDU control fields: START, HiLo, WRITE_ENABLED, MDU_OP and madd. It sequences mult/multu/div/divu/madd/maddu over a fixed latency, handles mthi/mtlo writes, and drives BUSY to the hazard unit. The hazard unit stalls D while START|BUSY holds and a later MDU instruction is waiting.

Parameters:
MULT_CYCLES, 5, BUSY cycles for mult/multu/madd/maddu (legal range 1..15)
DIV_CYCLES, 10, BUSY cycles for div/divu (legal range 1..15)
CNT_W, 4, countdown counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
START  in  1  E-stage MDU arithmetic instruction valid
MDU_OP  in  2  00 mult, 01 multu, 10 div, 11 divu
madd  in  1  accumulate into {HI,LO}; legal only with MDU_OP 00/01
WRITE_ENABLED  in  1  mthi/mtlo write strobe
HiLo  in  1  1 = HI, 0 = LO (write target and read select)
CANCEL  in  1  E-stage instruction is being flushed (exception/interrupt)
SRC_A  in  32  rs operand (forwarded)
SRC_B  in  32  rt operand (forwarded)
BUSY  out  1  operation in progress
HI  out  32  HI register
LO  out  32  LO register
RD_DATA  out  32  HiLo ? HI : LO (mfhi/mflo), combinational

Behaviour:
- Reset (reset=0, async): state IDLE, counter 0, BUSY=0, HI=0, LO=0, pending result registers 0. A reset in mid-operation aborts the operation with no commit.
- Qualified start: go = START & ~CANCEL & ~BUSY. Qualified write: wr = WRITE_ENABLED & ~CANCEL & ~BUSY & ~START. START and WRITE_ENABLED in the same cycle: START wins.
- States: IDLE, RUN.
- IDLE -> RUN on go:
  - Compute the result from SRC_A/SRC_B this cycle and latch it into PEND_HI/PEND_LO.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - BUSY goes 1 at the next edge.
- RUN: the counter decrements every cycle. When the counter is 1:
  - At that edge, commit PEND to HI/LO (if commit enabled), set BUSY=0, return to IDLE.
  - BUSY is therefore high for exactly N cycles, starting the cycle after START.
  - The new HI/LO are visible in the first cycle with BUSY=0.
- Multiply: 64-bit product {HI,LO}. Signed for op 00, unsigned for op 01.
- madd: {HI,LO} + product, modulo 2^64. HI/LO are sampled at the go cycle (they are stable while BUSY).
- Divide: LO = quotient (truncates toward zero), HI = remainder (sign follows the dividend). Signed for 10, unsigned for 11.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - SRC_B=0: full DIV_CYCLES BUSY sequence, commit suppressed, HI/LO unchanged.
- madd with MDU_OP 1x: treated as plain div/divu; madd is ignored.
- wr: at the edge, HI (HiLo=1) or LO (HiLo=0) <= SRC_A. BUSY stays 0.
- START or WRITE_ENABLED while BUSY: ignored with no state change. This is a hazard-unit bug indicator; assert in simulation.
- CANCEL during RUN: no effect. An operation already started completes and commits.
- RD_DATA reflects the committed HI/LO only, never PEND.

Decomposition:
- Shared package/header (head.v defines): MDU_OP encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU), state encodings (MDU_IDLE, MDU_RUN), default latency constants.
- One sub-module: mdu_arith. Purely combinational; takes op, madd, SRC_A, SRC_B, HI, LO and returns 64-bit {res_hi, res_lo} plus a div_by_zero flag.
- mdu_sequencer holds the FSM, counter, PEND registers and HI/LO.

Test Plan:
- Reset check: reset=0 mid-run at cycle 3 of a mult -> BUSY=0, HI=LO=0 immediately; no commit after reset is released.
- mult vs multu, SRC_A=0xFFFFFFFF, SRC_B=2:
  - mult -> BUSY high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - multu -> HI=0x00000001, LO=0xFFFFFFFE.
- div, SRC_A=0xFFFFFFF9 (-7), SRC_B=2 -> BUSY high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 -> BUSY 10 cycles, HI/LO unchanged.
- mtlo then maddu:
  - mtlo SRC_A=0xFFFFFFFF, then mthi SRC_A=0 -> LO/HI written the next cycle, BUSY stays 0.
  - Then maddu 1*1 -> HI=0x00000001, LO=0x00000000.
- Illegal/cancelled starts:
  - START with CANCEL=1 -> no BUSY, no change.
  - START asserted again during BUSY -> ignored; the original result commits on schedule.
  - START and WRITE_ENABLED in the same cycle -> arithmetic only.
- Signed overflow: div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. RD_DATA follows HiLo toggling each cycle.
